// File: rtl/wide_add_pkg.sv
// Shared definitions for the wide_add_sequencer block.
//   WORD_W    : width of the narrow adder slice
//   state_e   : sequencer FSM state encoding
//   cnt_width : word-counter width for a given word count (minimum 1)
package wide_add_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width: clog2 of the word count, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/carry_skip16bit.sv
// 16-bit carry-skip adder: four 4-bit ripple blocks, each with a bypass of
// the incoming block carry when every bit in the block propagates.
// Ports:
//   a, b   : 16-bit addends
//   cin    : carry-in
//   sum_c  : 16-bit sum (combinational)
//   cout_c : carry-out (combinational)
module carry_skip16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum_c,
    output logic        cout_c
);

    localparam int unsigned BLK_W   = 4;
    localparam int unsigned NUM_BLK = 4;

    logic blk_cin;
    logic rip_c;
    logic prop;
    logic prop_all;

    // Ripple inside each block; the block carry-out skips when all bits propagate.
    always_comb begin
        sum_c    = '0;
        blk_cin  = cin;
        rip_c    = 1'b0;
        prop     = 1'b0;
        prop_all = 1'b1;
        for (int unsigned blk = 0; blk < NUM_BLK; blk++) begin
            rip_c    = blk_cin;
            prop_all = 1'b1;
            for (int unsigned bt = 0; bt < BLK_W; bt++) begin
                prop                   = a[blk*BLK_W+bt] ^ b[blk*BLK_W+bt];
                sum_c[blk*BLK_W+bt]    = prop ^ rip_c;
                rip_c                  = (a[blk*BLK_W+bt] & b[blk*BLK_W+bt]) | (prop & rip_c);
                prop_all               = prop_all & prop;
            end
            blk_cin = prop_all ? blk_cin : rip_c;
        end
    end

    assign cout_c = blk_cin;

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: adds two NUM_WORDS x 16-bit operands one word per
// cycle (LSW first) through a single carry_skip16bit slice, with a registered
// carry between words and valid/ready handshakes on both sides.
// Optional build macro: WIDE_ADD_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, cin            : operands and carry-in, sampled on accept
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   sum, cout            : registered result, held until the next result
//   busy                 : high in RUN or DONE
//   ovf                  : signed overflow (only with WIDE_ADD_OVF_EN)
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] a,
    input  logic [WORD_W*NUM_WORDS-1:0] b,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] sum,
    output logic                        cout,
    output logic                        busy
`ifdef WIDE_ADD_OVF_EN
    ,
    output logic                        ovf
`endif
);

    localparam int unsigned W     = WORD_W * NUM_WORDS;
    localparam int unsigned CNT_W = cnt_width(NUM_WORDS);

    state_e             state_q;
    state_e             state_d;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WORD_W-1:0]  add_sum;
    logic               add_cout;
    logic [W-1:0]       sum_shift;
    logic               last_word;

    assign last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));

    // Single narrow datapath slice.
    carry_skip16bit u_add (
        .a      (a_sh[WORD_W-1:0]),
        .b      (b_sh[WORD_W-1:0]),
        .cin    (carry_q),
        .sum_c  (add_sum),
        .cout_c (add_cout)
    );

    // Partial-sum shift register: new word enters from the top. It only
    // needs the NUM_WORDS-1 earlier words; the current word completes it.
    generate
        if (NUM_WORDS > 1) begin : g_multi
            logic [W-WORD_W-1:0] sum_sh;

            assign sum_shift = {add_sum, sum_sh};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_sh <= '0;
                end else if (state_q == RUN) begin
                    sum_sh <= sum_shift[W-1:WORD_W];
                end
            end
        end else begin : g_single
            assign sum_shift = add_sum;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_word) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);

    // Operand capture, word sequencing and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> WORD_W;
                    b_sh    <= b_sh >> WORD_W;
                    carry_q <= add_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_word) begin
                        sum  <= sum_shift;
                        cout <= add_cout;
`ifdef WIDE_ADD_OVF_EN
                        // Top word is in the low slice now: same-sign inputs, different-sign result.
                        ovf  <= (a_sh[WORD_W-1] == b_sh[WORD_W-1]) &&
                                (add_sum[WORD_W-1] != a_sh[WORD_W-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed self-checking bench for wide_add_sequencer with NUM_WORDS = 4.
// Define WIDE_ADD_OVF_EN for both RTL and bench to exercise the ovf output.
module tb_wide_add_sequencer;

    localparam int unsigned NW = 4;
    localparam int unsigned W  = 16 * NW;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef WIDE_ADD_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    wide_add_sequencer #(.NUM_WORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef WIDE_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set, wait for the result and check it (out_ready held high).
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tcin, input logic [W-1:0] esum, input logic ecout,
                          input logic eovf);
        int lat;
        a        = ta;
        b        = tbv;
        cin      = tcin;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        a        = ~ta;   // later operand changes must not matter
        b        = ~tbv;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'd4);
        chk({tag, ".sum"}, sum, esum);
        chk({tag, ".cout"}, 64'(cout), 64'(ecout));
`ifdef WIDE_ADD_OVF_EN
        chk({tag, ".ovf"}, 64'(ovf), 64'(eovf));
`else
        if (eovf === 1'bx) $display("note: %s has undefined ovf expectation", tag);
`endif
        tick();
        chk({tag, ".one_cycle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [W-1:0] held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) tick();
        chk("rst.in_ready",  64'(in_ready),  64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.busy",      64'(busy),      64'd0);
        chk("rst.sum",       sum,            64'd0);
        chk("rst.cout",      64'(cout),      64'd0);
        rst = 1'b0;
        tick();

        run_op("ripple", 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               64'h0000_0000_0000_0000, 1'b1, 1'b0);
        run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
               64'h2222_2222_2222_2212, 1'b0, 1'b0);
        run_op("cin_prop", 64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1,
               64'h0001_0000_0000_0000, 1'b0, 1'b0);

        // Backpressure: result held in DONE while out_ready is low.
        out_ready = 1'b0;
        a         = 64'h0000_0000_0001_0000;
        b         = 64'h0000_0000_0000_FFFF;
        cin       = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp.latency", 64'(lat), 64'd4);
        chk("bp.sum", sum, 64'h0000_0000_0002_0000);
        held      = sum;
        a         = 64'd5;
        b         = 64'd7;
        cin       = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.out_valid", 64'(out_valid), 64'd1);
            chk("bp.in_ready",  64'(in_ready),  64'd0);
            chk("bp.sum_hold",  sum,            held);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp.idle_ready", 64'(in_ready),  64'd1);
        chk("bp.idle_valid", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("bp.second_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp.second_lat", 64'(lat), 64'd4);
        chk("bp.second_sum", sum, 64'd12);
        tick();

        // Reset mid-RUN aborts the request.
        a        = 64'hFFFF_0000_FFFF_0000;
        b        = 64'h0000_FFFF_0000_FFFF;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("abort.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.sum",       sum,            64'd0);
        chk("abort.in_ready",  64'(in_ready),  64'd1);
        chk("abort.busy",      64'(busy),      64'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort.no_result", 64'(seen), 64'd0);

`ifdef WIDE_ADD_OVF_EN
        run_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
               64'h0, 1'b1, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle wide adder that computes a NUM_WORDS×16-bit sum with a single 16-bit carry-skip adder. It processes one 16-bit word per cycle, least-significant word first, and registers the carry between words. It sits between a requester and a consumer with valid/ready handshakes on both sides. It is the sequencing controller that lets wide arithmetic reuse one narrow adder slice.

## Interface
Parameters:
- NUM_WORDS, default 4: number of 16-bit words per operand. Total width W = 16·NUM_WORDS. Must be ≥ 1.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: requester presents an operand set.
- in_ready  out  1: block can accept an operand set.
- a  in  W: operand A.
- b  in  W: operand B.
- cin  in  1: carry-in to word 0.
- out_valid  out  1: sum, cout (and ovf) are valid.
- out_ready  in  1: consumer takes the result.
- sum  out  W: registered result.
- cout  out  1: carry-out of the most-significant word.
- busy  out  1: high in RUN or DONE.
- ovf  out  1: signed overflow. Present only with WIDE_ADD_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from the state register.
- IDLE:
  - On in_valid && in_ready: load a and b into operand shift registers, load carry_q ← cin, clear word counter, go to RUN.
- RUN, each cycle:
  - Adder input is operand low words a_sh[15:0] + b_sh[15:0] + carry_q.
  - Adder 16-bit result shifts into sum_sh from the top; sum_sh shifts right by 16.
  - a_sh and b_sh shift right by 16.
  - carry_q ← adder cout; counter increments.
  - When counter == NUM_WORDS−1: copy the shifted-in sum to the sum output, set cout ← adder cout, go to DONE.
- DONE:
  - Hold sum, cout and ovf stable.
  - On out_ready, go to IDLE.
- Outputs hold their last value until the next result is written.
- Operand inputs are sampled only on the accept edge; later changes have no effect.
- in_valid while busy is not accepted and no state changes (in_ready = 0).
- Arithmetic is unsigned modulo 2^W; {cout, sum} = a + b + cin exactly.

## Timing
- Accept at edge T0. RUN occupies edges T1..T_NUM_WORDS. out_valid is high from T_NUM_WORDS.
- Latency from accept to out_valid: NUM_WORDS cycles.
- Minimum initiation interval: NUM_WORDS + 2 cycles; there is no accept in the same cycle as result handoff.
- With out_ready held high, out_valid is high for exactly 1 cycle.
- NUM_WORDS = 1: RUN lasts one cycle and the result is valid 1 cycle after accept.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, sum 0, cout 0, ovf 0, carry_q 0, counter 0.
- Reset asserted mid-RUN or in DONE: aborts immediately (asynchronous). No result is emitted, and outputs take reset values.

## Configuration
- WIDE_ADD_OVF_EN defined:
  - ovf port exists.
  - On the final RUN cycle, ovf ← (a_msb == b_msb) && (sum_msb != a_msb). MSBs are taken from the top word being added.
  - ovf holds with sum and resets to 0.
- WIDE_ADD_OVF_EN undefined: no ovf port and no overflow logic.

## Structure
- Shared package wide_add_pkg holds:
  - WORD_W = 16.
  - The state typedef {IDLE, RUN, DONE}.
  - Counter width, computed as clog2 of NUM_WORDS with a minimum of 1.
- One sub-module: the existing carry_skip16bit adder, instantiated exactly once as the datapath slice. There is no other arithmetic in the block.

## Test plan
All scenarios use NUM_WORDS = 4.
- Full carry ripple: a = 0x0000_0000_0000_0001, b = 0xFFFF_FFFF_FFFF_FFFF, cin = 0 → sum = 0, cout = 1, out_valid exactly 4 cycles after accept.
- Mixed words: a = 0x1234_5678_9ABC_DEF0, b = 0x0FED_CBA9_8765_4321, cin = 1 → sum = 0x2222_2222_2222_2212, cout = 0.
- Carry-in propagation: a = 0x0000_FFFF_FFFF_FFFF, b = 0, cin = 1 → sum = 0x0001_0000_0000_0000, cout = 0.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles in DONE → out_valid stays 1, sum stable, in_ready stays 0.
  - A second in_valid during this window is not accepted.
  - Raising out_ready → IDLE next cycle, then the second request is accepted.
- Reset mid-RUN: assert rst after 2 RUN cycles → out_valid 0, sum 0, in_ready 1. No result is ever produced for that request.
- With WIDE_ADD_OVF_EN:
  - a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 → sum = 0x8000_0000_0000_0000, ovf = 1, cout = 0.
  - a = b = 0x8000_0000_0000_0000 → sum = 0, cout = 1, ovf = 1.
